// File: rtl/sm_rf_pkg.sv
// Shared types and constants for the register-file writeback merge.
// The entry struct is stamped out per user so widths can follow parameters.
`define SM_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`define SM_RF_WB_ENTRY_S(name, aw, dw) \
  typedef struct packed { \
    logic            v; \
    logic [(aw)-1:0] addr; \
    logic [(dw)-1:0] data; \
  } name

package sm_rf_pkg;

  localparam int sm_width_gp      = 32;
  localparam int sm_els_gp        = 32;
  localparam int sm_addr_width_gp = `SM_SAFE_CLOG2(sm_els_gp);
  localparam int zero_reg_addr_gp = 0;

  `SM_RF_WB_ENTRY_S(wb_entry_s, sm_addr_width_gp, sm_width_gp);

endpackage

// File: rtl/sm_wb_queue.sv
// Circular queue of pending load writebacks with kill-by-address.
// Entries are presented in age order (index 0 = oldest) for forwarding.
module sm_wb_queue
  import sm_rf_pkg::*;
#(
  parameter int width_p      = 32,
  parameter int addr_width_p = 5,
  parameter int els_p        = 2,
  localparam int ptr_w_lp    = `SM_SAFE_CLOG2(els_p),
  localparam int cnt_w_lp    = $clog2(els_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enq_i,
  input  logic [addr_width_p-1:0]     enq_addr_i,
  input  logic [width_p-1:0]          enq_data_i,
  input  logic                        deq_i,
  input  logic                        kill_v_i,
  input  logic [addr_width_p-1:0]     kill_addr_i,
  output logic [cnt_w_lp-1:0]         count_o,
  output logic [els_p-1:0]            ent_v_o,
  output logic [els_p*addr_width_p-1:0] ent_addr_o,
  output logic [els_p*width_p-1:0]    ent_data_o
);

  `SM_RF_WB_ENTRY_S(entry_t, addr_width_p, width_p);

  entry_t              mem_q [els_p];
  logic [ptr_w_lp-1:0] head_q, tail_q;
  logic [cnt_w_lp-1:0] cnt_q;

  function automatic logic [ptr_w_lp-1:0] inc(
    input logic [ptr_w_lp-1:0] p
  );
    return (int'(p) == els_p - 1) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; kills clear valid bits at the edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < els_p; i++) begin
        if (kill_v_i && mem_q[i].v &&
            mem_q[i].addr == kill_addr_i)
          mem_q[i].v <= 1'b0;
      end
      if (enq_i) begin
        mem_q[tail_q] <= '{v: 1'b1,
                           addr: enq_addr_i,
                           data: enq_data_i};
        tail_q <= inc(tail_q);
      end
      if (deq_i) head_q <= inc(head_q);
      cnt_q <= cnt_q + cnt_w_lp'(enq_i)
                     - cnt_w_lp'(deq_i);
    end
  end

  // Rotate storage into age order; slots past the count read as invalid.
  always_comb begin
    logic [ptr_w_lp-1:0] idx;
    int                  s;
    ent_v_o    = '0;
    ent_addr_o = '0;
    ent_data_o = '0;
    for (int k = 0; k < els_p; k++) begin
      s = int'(head_q) + k;
      if (s >= els_p) s = s - els_p;
      idx = ptr_w_lp'(s);
      ent_v_o[k] = (k < int'(cnt_q)) && mem_q[idx].v;
      ent_addr_o[k*addr_width_p +: addr_width_p] = mem_q[idx].addr;
      ent_data_o[k*width_p +: width_p] = mem_q[idx].data;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/sm_rf_wb_merge.sv
// Writeback merge in front of a 2r1w register file: ALU vs load arbitration,
// a kill-able load queue, and youngest-value forwarding onto both read ports.
module sm_rf_wb_merge
  import sm_rf_pkg::*;
#(
  parameter int width_p       = 32,
  parameter int els_p         = 32,
  parameter int q_els_p       = 2,
  parameter int zero_reg_p    = 1,
  localparam int addr_width_lp = `SM_SAFE_CLOG2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     alu_v_i,
  input  logic [addr_width_lp-1:0] alu_addr_i,
  input  logic [width_p-1:0]       alu_data_i,
  input  logic                     mem_v_i,
  input  logic [addr_width_lp-1:0] mem_addr_i,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     mem_ready_o,
  output logic                     w_v_o,
  output logic [addr_width_lp-1:0] w_addr_o,
  output logic [width_p-1:0]       w_data_o,
  input  logic [addr_width_lp-1:0] r0_addr_i,
  input  logic [width_p-1:0]       r0_rf_data_i,
  output logic [width_p-1:0]       r0_data_o,
  input  logic [addr_width_lp-1:0] r1_addr_i,
  input  logic [width_p-1:0]       r1_rf_data_i,
  output logic [width_p-1:0]       r1_data_o
);

  localparam int aw_lp    = addr_width_lp;
  localparam int cnt_w_lp = $clog2(q_els_p + 1);
  localparam logic [aw_lp-1:0] zero_addr_lp =
    aw_lp'(zero_reg_addr_gp);
  localparam logic zr_lp = (zero_reg_p != 0);

  logic [cnt_w_lp-1:0]        q_cnt;
  logic [q_els_p-1:0]         q_ent_v;
  logic [q_els_p*aw_lp-1:0]   q_ent_addr;
  logic [q_els_p*width_p-1:0] q_ent_data;
  logic                       q_enq, q_deq;
  logic                       head_here, head_v;
  logic                       alu_eff, mem_eff;

  // Input qualification: zero-register drops and same-cycle ALU shadowing.
  always_comb begin
    mem_ready_o = int'(q_cnt) < q_els_p;
    alu_eff = alu_v_i &&
              !(zr_lp && alu_addr_i == zero_addr_lp);
    mem_eff = mem_v_i && mem_ready_o &&
              !(zr_lp && mem_addr_i == zero_addr_lp) &&
              !(alu_eff && alu_addr_i == mem_addr_i);
    head_here = q_cnt != '0;
    head_v    = q_ent_v[0];
  end

  // Write-port arbitration: ALU, then queue head, then load bypass.
  always_comb begin
    w_v_o    = 1'b0;
    w_addr_o = alu_addr_i;
    w_data_o = alu_data_i;
    q_deq    = 1'b0;
    if (alu_eff) begin
      w_v_o = 1'b1;
      q_deq = head_here && !head_v;
    end else if (head_v) begin
      w_v_o    = 1'b1;
      w_addr_o = q_ent_addr[aw_lp-1:0];
      w_data_o = q_ent_data[width_p-1:0];
      q_deq    = 1'b1;
    end else if (head_here) begin
      q_deq = 1'b1;
    end else if (mem_eff) begin
      w_v_o    = 1'b1;
      w_addr_o = mem_addr_i;
      w_data_o = mem_data_i;
    end
    q_enq = mem_eff && (alu_eff || head_here);
  end

  sm_wb_queue #(
    .width_p      (width_p),
    .addr_width_p (aw_lp),
    .els_p        (q_els_p)
  ) u_q (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enq_i       (q_enq),
    .enq_addr_i  (mem_addr_i),
    .enq_data_i  (mem_data_i),
    .deq_i       (q_deq),
    .kill_v_i    (alu_eff),
    .kill_addr_i (alu_addr_i),
    .count_o     (q_cnt),
    .ent_v_o     (q_ent_v),
    .ent_addr_o  (q_ent_addr),
    .ent_data_o  (q_ent_data)
  );

  logic [aw_lp-1:0]   rd_addr [2];
  logic [width_p-1:0] rd_rf   [2];
  logic [width_p-1:0] rd_fwd  [2];

  assign rd_addr[0] = r0_addr_i;
  assign rd_addr[1] = r1_addr_i;
  assign rd_rf[0]   = r0_rf_data_i;
  assign rd_rf[1]   = r1_rf_data_i;

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    logic [width_p-1:0] fwd;

    // Oldest source first so each younger match overrides.
    always_comb begin
      fwd = rd_rf[g];
      for (int k = 0; k < q_els_p; k++) begin
        if (q_ent_v[k] &&
            q_ent_addr[k*aw_lp +: aw_lp] == rd_addr[g])
          fwd = q_ent_data[k*width_p +: width_p];
      end
      if (mem_eff && mem_addr_i == rd_addr[g])
        fwd = mem_data_i;
      if (alu_eff && alu_addr_i == rd_addr[g])
        fwd = alu_data_i;
      if (zr_lp && rd_addr[g] == zero_addr_lp)
        fwd = '0;
    end

    assign rd_fwd[g] = fwd;
  end

  assign r0_data_o = rd_fwd[0];
  assign r1_data_o = rd_fwd[1];

endmodule
